// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared definitions for the ID/EX pipeline register.
//               Holds the control-bundle layout, the WDSel/NPCOp encodings
//               and the bubble constant.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    // Packed decoder bundle, MSB first:
    // {RegWrite,MemWrite,EXTOp[5:0],ALUOp[4:0],NPCOp[2:0],ALUSrc,
    //  DMType[2:0],GPRSel[1:0],WDSel[1:0]}
    localparam int CTRL_W       = 24;
    localparam int REGWRITE_BIT = 23;
    localparam int MEMWRITE_BIT = 22;
    localparam int EXTOP_LSB    = 16;
    localparam int ALUOP_LSB    = 11;
    localparam int NPCOP_LSB    = 8;
    localparam int ALUSRC_BIT   = 7;
    localparam int DMTYPE_LSB   = 4;
    localparam int GPRSEL_LSB   = 2;
    localparam int WDSEL_LSB    = 0;
    localparam int WDSEL_W      = 2;

    localparam logic [1:0] WDSEL_FROM_MEM = 2'b01;
    localparam logic [2:0] NPC_PLUS4      = 3'b000;

    // All-zero bundle: no register/memory write, sequential next-PC,
    // ALU result as write-back source.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    function automatic logic [WDSEL_W-1:0] ctrl_wdsel(input logic [CTRL_W-1:0] ctrl);
        return ctrl[WDSEL_LSB +: WDSEL_W];
    endfunction

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Ports       : clk   - rising-edge clock
//               rstn  - asynchronous active-low reset, clears count
//               inc   - increment enable for this edge
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use hazard detection,
//               flush/hold handling and stall/flush performance counters.
// Ports       : clk, rstn              - clock, async active-low reset
//               id_*                   - decoded instruction from ID
//               ex_flush               - taken control transfer in EX
//               hold                   - global freeze
//               load_use_stall         - freeze PC and IF/ID this cycle
//               ex_*                   - registered EX-stage contents
//               stall_cnt, flush_cnt   - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_flush,
    input  logic              hold,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic w_ex_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_hazard;

    // A bubble has ex_valid=0, so it can never look like a pending load;
    // x0 destinations never produce a dependency.
    assign w_ex_is_load = ex_valid && (ctrl_wdsel(ex_ctrl) == WDSEL_FROM_MEM) && (ex_rd != 5'd0);
    assign w_rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
    assign w_hazard     = w_ex_is_load && id_valid && (w_rs1_hit || w_rs2_hit);

    // A flush discards the dependent instruction anyway, so no stall.
    // Deliberately independent of hold: the front end must stay frozen.
    assign load_use_stall = w_hazard && !ex_flush;

    // Priority per edge: hold > flush > hazard > normal load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_ctrl     <= CTRL_BUBBLE;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else if (!hold) begin
            if (ex_flush || w_hazard) begin
                ex_valid    <= 1'b0;
                ex_pc       <= '0;
                ex_ctrl     <= CTRL_BUBBLE;
                ex_rs1_data <= '0;
                ex_rs2_data <= '0;
                ex_imm      <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rd       <= '0;
            end else begin
                ex_valid    <= id_valid;
                ex_pc       <= id_pc;
                // An empty ID slot must not carry stray write enables.
                ex_ctrl     <= id_valid ? id_ctrl : CTRL_BUBBLE;
                ex_rs1_data <= id_rs1_data;
                ex_rs2_data <= id_rs2_data;
                ex_imm      <= id_imm;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (load_use_stall && !hold),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (ex_flush && !hold),
        .count (flush_cnt)
    );

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A reference model
//               predicts the EX registers and counters for each edge; the
//               prediction is queued when inputs are driven and compared
//               after the edge. A second instance with 4-bit counters
//               exercises saturation in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam logic [23:0] LW_CTRL  = 24'h800081; // RegWrite, ALUSrc, WDSel=01
    localparam logic [23:0] ADD_CTRL = 24'h800800; // RegWrite, ALUOp, WDSel=00

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid, id_use_rs1, id_use_rs2, ex_flush, hold;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [23:0] id_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic        load_use_stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [23:0] ex_ctrl;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_load_use_stall, s_ex_valid;
    logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [23:0] s_ex_ctrl;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_flush(ex_flush), .hold(hold),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_flush(ex_flush), .hold(hold),
        .load_use_stall(s_load_use_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
        .ex_ctrl(s_ex_ctrl), .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data),
        .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic        m_valid;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [23:0] m_ctrl;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    int          m_sc, m_fc, m_sc4, m_fc4;

    typedef struct packed {
        logic [167:0] ex;
        logic [15:0]  sc;
        logic [15:0]  fc;
        logic [3:0]   sc4;
        logic [3:0]   fc4;
    } exp_t;

    exp_t sb_q[$];

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_ctrl = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ex"}, 192'({ex_valid, ex_pc, ex_ctrl, ex_rs1_data, ex_rs2_data,
                                     ex_imm, ex_rs1, ex_rs2, ex_rd}), 192'(0));
        check_eq({tag, "_cnt"}, 192'({stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt}), 192'(0));
        check_eq({tag, "_stall"}, 192'(load_use_stall), 192'(0));
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [23:0] ctrl,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic fl, input logic hd);
        id_valid = v; id_pc = pc; id_ctrl = ctrl;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; ex_flush = fl; hold = hd;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic haz, stl;
        exp_t e;
        #1;
        haz = m_valid && (m_ctrl[1:0] == 2'b01) && (m_rd != 5'd0) && id_valid &&
              ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
        stl = haz && !ex_flush;
        check_eq("load_use_stall", 192'(load_use_stall), 192'(stl));
        if (!hold) begin
            if (stl) begin
                if (m_sc  < 65535) m_sc++;
                if (m_sc4 < 15)    m_sc4++;
            end
            if (ex_flush) begin
                if (m_fc  < 65535) m_fc++;
                if (m_fc4 < 15)    m_fc4++;
            end
            if (ex_flush || haz) begin
                m_valid = 1'b0; m_pc = '0; m_ctrl = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
                m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            end else begin
                m_valid = id_valid; m_pc = id_pc; m_ctrl = id_valid ? id_ctrl : 24'h0;
                m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
                m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            end
        end
        e.ex  = {m_valid, m_pc, m_ctrl, m_d1, m_d2, m_imm, m_rs1, m_rs2, m_rd};
        e.sc  = 16'(m_sc);
        e.fc  = 16'(m_fc);
        e.sc4 = 4'(m_sc4);
        e.fc4 = 4'(m_fc4);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("ex_regs", 192'({ex_valid, ex_pc, ex_ctrl, ex_rs1_data, ex_rs2_data,
                                  ex_imm, ex_rs1, ex_rs2, ex_rd}), 192'(e.ex));
        check_eq("stall_cnt", 192'(stall_cnt), 192'(e.sc));
        check_eq("flush_cnt", 192'(flush_cnt), 192'(e.fc));
        check_eq("stall_cnt_w4", 192'(s_stall_cnt), 192'(e.sc4));
        check_eq("flush_cnt_w4", 192'(s_flush_cnt), 192'(e.fc4));
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        // lw x5 then dependent add x6,x5,x7: one stall, then add captured
        drive(1, 32'h10, LW_CTRL, 5'd2, 5'd0, 5'd5, 1, 0, 0, 0);  step();
        drive(1, 32'h14, ADD_CTRL, 5'd5, 5'd7, 5'd6, 1, 1, 0, 0); step();
        check_eq("lu_bubble", 192'({ex_valid, ex_ctrl, stall_cnt}), 192'({1'b0, 24'h0, 16'd1}));
        step();
        check_eq("lu_capture_pc", 192'(ex_pc), 192'(32'h14));

        // lw x0 followed by reader of x0: no stall
        drive(1, 32'h20, LW_CTRL, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0);  step();
        drive(1, 32'h24, ADD_CTRL, 5'd0, 5'd0, 5'd8, 1, 1, 0, 0); step();

        // hazard and flush in the same cycle
        drive(1, 32'h30, LW_CTRL, 5'd1, 5'd0, 5'd9, 1, 0, 0, 0);  step();
        drive(1, 32'h34, ADD_CTRL, 5'd9, 5'd3, 5'd4, 0, 1, 1, 0); step();

        // hold with a live hazard for 3 cycles, PC changing
        drive(1, 32'h40, LW_CTRL, 5'd1, 5'd0, 5'd7, 1, 0, 0, 0);  step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h100 + 32'(4 * i), ADD_CTRL, 5'd7, 5'd2, 5'd3, 1, 0, 0, 1);
            step();
        end
        check_eq("hold_pc", 192'(ex_pc), 192'(32'h40));
        drive(1, 32'h10c, ADD_CTRL, 5'd7, 5'd2, 5'd3, 1, 0, 0, 0); step();
        step();

        // empty ID slot carrying junk control
        drive(0, 32'h50, 24'hFFFFFF, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0); step();

        // random traffic with small register indices to provoke hazards
        for (int i = 0; i < 300; i++) begin
            logic [23:0] c;
            c = 24'($urandom);
            if ($urandom_range(0, 1) == 1) c[1:0] = 2'b01;
            drive($urandom_range(0, 7) != 0, $urandom, c,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            step();
        end

        // back-to-back lw x5,0(x5): a stall every other cycle, saturates w4 counter
        for (int i = 0; i < 40; i++) begin
            drive(1, 32'h200, LW_CTRL, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0);
            step();
        end
        check_eq("sat_w4", 192'(s_stall_cnt), 192'(4'hF));

        // asynchronous reset between edges while EX holds a valid op, during hold
        drive(1, 32'h300, ADD_CTRL, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0); step();
        drive(1, 32'h304, ADD_CTRL, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        drive(1, 32'h400, ADD_CTRL, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0); step();
        check_eq("post_reset_load", 192'({ex_valid, ex_pc}), 192'({1'b1, 32'h400}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire
